// File: rtl/riscv_defines.sv
// Shared trap definitions: FSM state encoding, selected-trap kind and RISC-V cause codes.
package riscv_defines;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_SAVE,
    ST_REDIRECT,
    ST_RET
  } trap_state_t;

  typedef enum logic [1:0] {
    KIND_NONE,
    KIND_EXC,
    KIND_MRET,
    KIND_IRQ
  } trap_kind_t;

  localparam logic [3:0]  EXC_INSTR_MISALIGN = 4'd0;
  localparam logic [3:0]  EXC_ILLEGAL        = 4'd2;
  localparam logic [3:0]  EXC_BREAKPOINT     = 4'd3;
  localparam logic [3:0]  EXC_ECALL_M        = 4'd11;
  localparam logic [31:0] IRQ_M_EXT_CAUSE    = 32'h8000_000B;

endpackage

// File: rtl/trap_prio.sv
// Combinational trap arbiter: exception beats mret, which beats an enabled external interrupt.
module trap_prio
  import riscv_defines::*;
(
  input  logic        exc_valid_i,
  input  logic [3:0]  exc_cause_i,
  input  logic [31:0] exc_pc_i,
  input  logic        mret_i,
  input  logic        irq_i,
  input  logic        mie_i,
  input  logic [31:0] next_pc_i,
  output trap_kind_t  kind_o,
  output logic [31:0] cause_o,
  output logic [31:0] pc_o
);

  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    kind_o  = KIND_NONE;
    cause_o = 32'h0;
    pc_o    = 32'h0;
    if (exc_valid_i) begin
      kind_o  = KIND_EXC;
      cause_o = {28'h0, exc_cause_i};
      pc_o    = exc_pc_i;
    end else if (mret_i) begin
      kind_o  = KIND_MRET;
    end else if (irq_i && mie_i) begin
      kind_o  = KIND_IRQ;
      cause_o = IRQ_M_EXT_CAUSE;
      pc_o    = next_pc_i;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer: drain pipeline, pulse EPC save, redirect fetch to the trap vector or to mepc on mret.
// Build option: define TRAP_VECTORED_EN to vector interrupts to MTVEC + 4*cause[3:0].
module trap_ctrl
  import riscv_defines::*;
#(
  parameter logic [31:0] MTVEC = 32'h0000_0100
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        exc_valid_i,
  input  logic [3:0]  exc_cause_i,
  input  logic [31:0] exc_pc_i,
  input  logic        mret_i,
  input  logic        irq_i,
  input  logic        mie_i,
  input  logic [31:0] next_pc_i,
  input  logic        drain_ack_i,
  input  logic [31:0] epc_i,
  output logic        flush_o,
  output logic        save_epc_o,
  output logic [31:0] epc_pc_o,
  output logic        mret_o,
  output logic        redirect_o,
  output logic [31:0] redirect_pc_o,
  output logic [31:0] mcause_o,
  output logic        busy_o
);

  trap_state_t state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] cause_q, cause_d;
  logic [31:0] mcause_q, mcause_d;

  trap_kind_t  sel_kind;
  logic [31:0] sel_cause;
  logic [31:0] sel_pc;
  logic [31:0] vector_pc;

  trap_prio u_prio (
    .exc_valid_i (exc_valid_i),
    .exc_cause_i (exc_cause_i),
    .exc_pc_i    (exc_pc_i),
    .mret_i      (mret_i),
    .irq_i       (irq_i),
    .mie_i       (mie_i),
    .next_pc_i   (next_pc_i),
    .kind_o      (sel_kind),
    .cause_o     (sel_cause),
    .pc_o        (sel_pc)
  );

  // NOTE: state uses non-blocking assignments; the async reset clears everything so an
  // interrupted sequence leaves no stale pc/cause behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      pc_q     <= 32'h0;
      cause_q  <= 32'h0;
      mcause_q <= 32'h0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cause_q  <= cause_d;
      mcause_q <= mcause_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    cause_d  = cause_q;
    mcause_d = mcause_q;
    unique case (state_q)
      ST_IDLE: begin
        unique case (sel_kind)
          KIND_EXC, KIND_IRQ: begin
            state_d = ST_DRAIN;
            pc_d    = sel_pc;
            cause_d = sel_cause;
          end
          KIND_MRET: state_d = ST_RET;
          default:   state_d = ST_IDLE;
        endcase
      end
      ST_DRAIN:    if (drain_ack_i) state_d = ST_SAVE;
      ST_SAVE: begin
        state_d  = ST_REDIRECT;
        mcause_d = cause_q;
      end
      ST_REDIRECT: state_d = ST_IDLE;
      ST_RET:      state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

`ifdef TRAP_VECTORED_EN
  assign vector_pc = cause_q[31] ? (MTVEC + {26'h0, cause_q[3:0], 2'b00}) : MTVEC;
`else
  assign vector_pc = MTVEC;
`endif

  always_comb begin
    flush_o       = 1'b0;
    save_epc_o    = 1'b0;
    epc_pc_o      = 32'h0;
    mret_o        = 1'b0;
    redirect_o    = 1'b0;
    redirect_pc_o = 32'h0;
    unique case (state_q)
      ST_DRAIN: flush_o = 1'b1;
      ST_SAVE: begin
        save_epc_o = 1'b1;
        epc_pc_o   = pc_q;
      end
      ST_REDIRECT: begin
        redirect_o    = 1'b1;
        redirect_pc_o = vector_pc;
      end
      ST_RET: begin
        mret_o        = 1'b1;
        redirect_o    = 1'b1;
        redirect_pc_o = epc_i;
      end
      default: ;
    endcase
  end

  assign mcause_o = mcause_q;
  assign busy_o   = (state_q != ST_IDLE);

  // A new exception cannot be accepted mid-sequence; the pipeline must hold it off while busy.
  assert property (@(posedge clk) disable iff (!rst_n) !(exc_valid_i && busy_o))
    else $error("trap_ctrl: exc_valid_i asserted while busy");

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl: reset, exception, interrupt, masked irq, mret, priority, mid-drain reset.
module tb_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        exc_valid_i;
  logic [3:0]  exc_cause_i;
  logic [31:0] exc_pc_i;
  logic        mret_i;
  logic        irq_i;
  logic        mie_i;
  logic [31:0] next_pc_i;
  logic        drain_ack_i;
  logic [31:0] epc_i;
  logic        flush_o;
  logic        save_epc_o;
  logic [31:0] epc_pc_o;
  logic        mret_o;
  logic        redirect_o;
  logic [31:0] redirect_pc_o;
  logic [31:0] mcause_o;
  logic        busy_o;

  int n_checks = 0;
  int n_pass   = 0;
  logic seen_mret, seen_save, seen_any;

`ifdef TRAP_VECTORED_EN
  localparam logic [31:0] IRQ_VEC = 32'h0000_012C;
`else
  localparam logic [31:0] IRQ_VEC = 32'h0000_0100;
`endif

  always #5 clk = ~clk;

  trap_ctrl dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .exc_valid_i   (exc_valid_i),
    .exc_cause_i   (exc_cause_i),
    .exc_pc_i      (exc_pc_i),
    .mret_i        (mret_i),
    .irq_i         (irq_i),
    .mie_i         (mie_i),
    .next_pc_i     (next_pc_i),
    .drain_ack_i   (drain_ack_i),
    .epc_i         (epc_i),
    .flush_o       (flush_o),
    .save_epc_o    (save_epc_o),
    .epc_pc_o      (epc_pc_o),
    .mret_o        (mret_o),
    .redirect_o    (redirect_o),
    .redirect_pc_o (redirect_pc_o),
    .mcause_o      (mcause_o),
    .busy_o        (busy_o)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  // Advance to the next falling edge, where outputs are stable, and note any strobes seen.
  task automatic cyc();
    @(negedge clk);
    seen_mret = seen_mret | mret_o;
    seen_save = seen_save | save_epc_o;
    seen_any  = seen_any | flush_o | save_epc_o | mret_o | redirect_o;
  endtask

  function automatic logic [31:0] all_outs();
    return {25'h0, flush_o, save_epc_o, mret_o, redirect_o, busy_o, |epc_pc_o, |redirect_pc_o}
           | mcause_o;
  endfunction

  initial begin
    rst_n = 1'b0; exc_valid_i = 1'b0; exc_cause_i = 4'h0; exc_pc_i = 32'h0;
    mret_i = 1'b0; irq_i = 1'b0; mie_i = 1'b0; next_pc_i = 32'h0;
    drain_ack_i = 1'b0; epc_i = 32'h0;
    seen_mret = 1'b0; seen_save = 1'b0; seen_any = 1'b0;

    // 1: reset state, then idle for 10 cycles
    #3;
    check("rst_outputs", all_outs(), 32'h0);
    check("rst_busy", {31'h0, busy_o}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    seen_any = 1'b0;
    for (int i = 0; i < 10; i++) cyc();
    check("idle_no_strobes", {31'h0, seen_any}, 32'h0);
    check("idle_busy", {31'h0, busy_o}, 32'h0);

    // 2: illegal-instruction exception, ack on the first DRAIN cycle
    exc_valid_i = 1'b1; exc_cause_i = 4'd2; exc_pc_i = 32'h80;
    cyc();
    check("exc_flush", {31'h0, flush_o}, 32'h1);
    check("exc_busy", {31'h0, busy_o}, 32'h1);
    check("exc_no_save_yet", {31'h0, save_epc_o}, 32'h0);
    exc_valid_i = 1'b0; drain_ack_i = 1'b1;
    cyc();
    check("exc_save", {31'h0, save_epc_o}, 32'h1);
    check("exc_epc_pc", epc_pc_o, 32'h80);
    check("exc_save_noflush", {31'h0, flush_o}, 32'h0);
    drain_ack_i = 1'b0;
    cyc();
    check("exc_redirect", {31'h0, redirect_o}, 32'h1);
    check("exc_redirect_pc", redirect_pc_o, 32'h100);
    check("exc_mcause", mcause_o, 32'h2);
    check("exc_save_oneshot", {31'h0, save_epc_o}, 32'h0);
    check("exc_epc_pc_zero", epc_pc_o, 32'h0);
    cyc();
    check("exc_done_busy", {31'h0, busy_o}, 32'h0);
    check("exc_redirect_oneshot", {31'h0, redirect_o}, 32'h0);
    check("exc_redirect_pc_zero", redirect_pc_o, 32'h0);

    // 3: external interrupt, drain takes three cycles
    irq_i = 1'b1; mie_i = 1'b1; next_pc_i = 32'h44;
    cyc();
    check("irq_flush_c1", {31'h0, flush_o}, 32'h1);
    cyc();
    check("irq_flush_c2", {31'h0, flush_o}, 32'h1);
    cyc();
    check("irq_flush_c3", {31'h0, flush_o}, 32'h1);
    drain_ack_i = 1'b1;
    cyc();
    check("irq_save", {31'h0, save_epc_o}, 32'h1);
    check("irq_epc_pc", epc_pc_o, 32'h44);
    drain_ack_i = 1'b0; mie_i = 1'b0;
    cyc();
    check("irq_redirect", {31'h0, redirect_o}, 32'h1);
    check("irq_redirect_pc", redirect_pc_o, IRQ_VEC);
    check("irq_mcause", mcause_o, 32'h8000_000B);
    seen_any = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    check("irq_no_reentry", {31'h0, seen_any}, 32'h0);
    check("irq_idle_busy", {31'h0, busy_o}, 32'h0);

    // 4: masked interrupt is ignored, then mret
    seen_any = 1'b0;
    for (int i = 0; i < 20; i++) cyc();
    check("masked_irq_quiet", {31'h0, seen_any}, 32'h0);
    mret_i = 1'b1; epc_i = 32'h200;
    cyc();
    check("mret_pulse", {31'h0, mret_o}, 32'h1);
    check("mret_redirect", {31'h0, redirect_o}, 32'h1);
    check("mret_redirect_pc", redirect_pc_o, 32'h200);
    check("mret_no_flush", {31'h0, flush_o}, 32'h0);
    mret_i = 1'b0;
    cyc();
    check("mret_oneshot", {31'h0, mret_o}, 32'h0);
    check("mret_done_busy", {31'h0, busy_o}, 32'h0);
    irq_i = 1'b0;

    // 5: exception, mret and enabled irq in the same cycle
    seen_mret = 1'b0;
    exc_valid_i = 1'b1; exc_cause_i = 4'd11; exc_pc_i = 32'h300;
    mret_i = 1'b1; irq_i = 1'b1; mie_i = 1'b1; next_pc_i = 32'h44;
    cyc();
    check("prio_flush", {31'h0, flush_o}, 32'h1);
    exc_valid_i = 1'b0; mret_i = 1'b0; irq_i = 1'b0; drain_ack_i = 1'b1;
    cyc();
    check("prio_epc_pc", epc_pc_o, 32'h300);
    drain_ack_i = 1'b0;
    cyc();
    check("prio_redirect_pc", redirect_pc_o, 32'h100);
    check("prio_mcause", mcause_o, 32'hB);
    cyc();
    check("prio_no_mret", {31'h0, seen_mret}, 32'h0);
    check("prio_done_busy", {31'h0, busy_o}, 32'h0);

    // 6: reset in the middle of DRAIN
    exc_valid_i = 1'b1; exc_cause_i = 4'd3; exc_pc_i = 32'h500;
    cyc();
    check("rst6_flush", {31'h0, flush_o}, 32'h1);
    exc_valid_i = 1'b0; drain_ack_i = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    check("rst6_flush_cleared", {31'h0, flush_o}, 32'h0);
    check("rst6_busy", {31'h0, busy_o}, 32'h0);
    check("rst6_mcause", mcause_o, 32'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    seen_save = 1'b0;
    for (int i = 0; i < 5; i++) cyc();
    check("rst6_no_save", {31'h0, seen_save}, 32'h0);
    check("rst6_idle", {31'h0, busy_o}, 32'h0);
    check("rst6_mcause_after", mcause_o, 32'h0);
    drain_ack_i = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
